// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised pipeline FIFO family.
package fifo_pkg;

  localparam int DATA_W_DEF = 32;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO producer/consumer and sync_fifo_param.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) ();

  localparam int AW = clog2(DEPTH);

  logic              flush;
  logic              wren;
  logic [DATA_W-1:0] din;
  logic              rden;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wren, din, rden,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wren, din, rden,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read (read-before-write).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   re,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Same-address write and read in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with protected wrap-bit pointers, sticky errors and registered read data.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]  PTR_ZERO  = {(AW+1){1'b0}};
  localparam logic [31:0]  AFULL_U   = AFULL_LVL;
  localparam logic [31:0]  AEMPTY_U  = AEMPTY_LVL;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_LVL > DEPTH) begin : g_bad_params
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2 and AFULL_LVL <= DEPTH");
  end

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              dv_q, dv_d;
  logic              rd_seen_q, rd_seen_d;
  logic              full_s, empty_s;
  logic              wr_acc_s, rd_acc_s;
  logic [AW:0]       count_s;
  logic [DATA_W-1:0] ram_rdata_s;

  always_comb begin
    count_s = wr_ptr_q - rd_ptr_q;
    full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_s = (wr_ptr_q == rd_ptr_q);
  end

  // Accept decisions use pre-edge state; flush suppresses both requests.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    dv_d      = 1'b0;
    rd_seen_d = rd_seen_q;
    wr_acc_s  = 1'b0;
    rd_acc_s  = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      wr_acc_s = bus.wren & (~full_s | bus.rden);
      rd_acc_s = bus.rden & ~empty_s;
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      ovf_d     = ovf_q | (bus.wren & full_s & ~bus.rden);
      udf_d     = udf_q | (bus.rden & empty_s);
      dv_d      = rd_acc_s;
      rd_seen_d = rd_seen_q | rd_acc_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      dv_q      <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      dv_q      <= dv_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.din),
    .re    (rd_acc_s),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // The RAM read register is not reset, so dout reads zero until the first accepted read.
  always_comb begin
    bus.dout         = rd_seen_q ? ram_rdata_s : {DATA_W{1'b0}};
    bus.dout_valid   = dv_q;
    bus.count        = count_s;
    bus.full         = full_s;
    bus.empty        = empty_s;
    bus.almost_full  = (32'(count_s) >= AFULL_U);
    bus.almost_empty = (32'(count_s) <= AEMPTY_U);
    bus.overflow     = ovf_q;
    bus.underflow    = udf_q;
  end

endmodule
